// File: rtl/soc_arb_pkg.sv
// Shared types and constants for the SOC fabric arbiter and its watchdog.
package soc_arb_pkg;

    localparam int NUM_MST   = 2;
    localparam int TMO_CNT_W = 16;

    typedef enum logic {IDLE, BUSY} arb_state_t;
    typedef logic [NUM_MST-1:0] gnt_t;

    function automatic gnt_t idx2gnt(input logic idx);
        return gnt_t'(1) << idx;
    endfunction

endpackage

// File: rtl/soc_arb_wdog.sv
// Bus watchdog: counts cycles of an outstanding access, flags expiry and keeps
// a saturating tally of expiries.
module soc_arb_wdog
    import soc_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 run,
    input  logic                 clr,
    output logic                 hit,
    output logic [TMO_CNT_W-1:0] tmo_cnt
);

    localparam int unsigned    CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit             WDOG_EN = (TIMEOUT_CYC != 0);
    localparam logic [CW-1:0]  LAST    = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0]        r_cnt;
    logic [TMO_CNT_W-1:0] r_tmo_cnt;

    // The caller only raises run while the access is still live and unanswered,
    // so a same-cycle slave completion can never be counted as an expiry.
    assign hit     = WDOG_EN && run && (r_cnt == LAST);
    assign tmo_cnt = r_tmo_cnt;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt     <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (clr || hit) begin
                r_cnt <= '0;
            end else if (run) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (hit && (r_tmo_cnt != '1)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_bus_arb.sv
// Two-master arbiter in front of one soc_if slave: per-transaction grant,
// round-robin or fixed priority, with a watchdog against hung slaves.
module soc_bus_arb
    import soc_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC  = 1024,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF,
    parameter bit          FIXED_PRIO   = 1'b0
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 m0_vld,
    input  logic [3:0]           m0_we,
    input  logic [29:0]          m0_addr,
    input  logic [31:0]          m0_wdat,
    output logic                 m0_rdy,
    output logic [31:0]          m0_rdat,
    input  logic                 m1_vld,
    input  logic [3:0]           m1_we,
    input  logic [29:0]          m1_addr,
    input  logic [31:0]          m1_wdat,
    output logic                 m1_rdy,
    output logic [31:0]          m1_rdat,
    output logic                 s_vld,
    output logic [3:0]           s_we,
    output logic [29:0]          s_addr,
    output logic [31:0]          s_wdat,
    input  logic                 s_rdy,
    input  logic [31:0]          s_rdat,
    output logic [NUM_MST-1:0]   gnt,
    output logic                 tmo_pulse,
    output logic [TMO_CNT_W-1:0] tmo_cnt
);

    arb_state_t r_state, w_state_nxt;
    gnt_t       r_gnt, w_gnt_nxt;
    logic       r_last, w_last_nxt;   // index of the master that last completed

    logic        w_g;
    logic        w_g_vld;
    logic [3:0]  w_g_we;
    logic [29:0] w_g_addr;
    logic [31:0] w_g_wdat;
    logic        w_busy;
    logic        w_rdy;
    logic [31:0] w_rdat;
    logic        w_run;
    logic        w_clr;
    logic        w_hit;

    assign w_busy   = (r_state == BUSY);
    assign w_g      = r_gnt[1];
    assign w_g_vld  = w_g ? m1_vld  : m0_vld;
    assign w_g_we   = w_g ? m1_we   : m0_we;
    assign w_g_addr = w_g ? m1_addr : m0_addr;
    assign w_g_wdat = w_g ? m1_wdat : m0_wdat;

    assign w_run = w_busy && w_g_vld && !s_rdy;
    assign w_clr = w_busy && (s_rdy || !w_g_vld);

    soc_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .arst    (arst),
        .run     (w_run),
        .clr     (w_clr),
        .hit     (w_hit),
        .tmo_cnt (tmo_cnt)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        s_vld       = 1'b0;
        s_we        = '0;
        s_addr      = '0;
        s_wdat      = '0;
        w_rdy       = 1'b0;
        w_rdat      = '0;
        tmo_pulse   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (m0_vld || m1_vld) begin
                    w_state_nxt = BUSY;
                    if (m0_vld && m1_vld) begin
                        w_gnt_nxt = FIXED_PRIO ? idx2gnt(1'b0) : idx2gnt(~r_last);
                    end else begin
                        w_gnt_nxt = idx2gnt(m1_vld);
                    end
                end
            end
            BUSY: begin
                s_vld     = w_g_vld && !w_hit;
                s_we      = w_g_we;
                s_addr    = w_g_addr;
                s_wdat    = w_g_wdat;
                w_rdy     = s_rdy || w_hit;
                w_rdat    = w_hit ? TIMEOUT_DATA : s_rdat;
                tmo_pulse = w_hit;
                if (s_rdy || w_hit) begin
                    w_last_nxt  = w_g;
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end else if (!w_g_vld) begin
                    // Master withdrew mid-access: drop it without touching fairness.
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase

        m0_rdy  = w_rdy && !w_g;
        m1_rdy  = w_rdy && w_g;
        m0_rdat = (w_busy && !w_g) ? w_rdat : '0;
        m1_rdat = (w_busy && w_g)  ? w_rdat : '0;
    end

    assign gnt = r_gnt;

endmodule

// File: tb/tb_soc_bus_arb.sv
// Bench for soc_bus_arb: a round-robin and a fixed-priority instance share one
// transaction-level reference model; directed scenarios pin it, random traffic follows.
module tb_soc_bus_arb;

    localparam int          T  = 16;
    localparam logic [31:0] TD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic arst;

    logic        m_vld  [2][2];
    logic [3:0]  m_we   [2][2];
    logic [29:0] m_addr [2][2];
    logic [31:0] m_wdat [2][2];
    logic        m_rdy  [2][2];
    logic [31:0] m_rdat [2][2];
    logic        s_vld  [2];
    logic [3:0]  s_we   [2];
    logic [29:0] s_addr [2];
    logic [31:0] s_wdat [2];
    logic        s_rdy  [2];
    logic [31:0] s_rdat [2];
    logic [1:0]  gnt    [2];
    logic        tmo_pulse [2];
    logic [15:0] tmo_cnt   [2];

    int n_chk = 0;
    int n_err = 0;

    // Reference model: which master owns the bus (-1 = nobody), how long it has
    // owned it, who finished last, and how many timeouts were taken.
    int md_cur  [2];
    int md_age  [2];
    int md_last [2];
    int md_tmo  [2];
    bit exp_rdy_q [2][2];

    logic [1:0] gnt_log0 [$];
    int         fp_viol = 0;
    int         slave_lat [2];

    soc_bus_arb #(.TIMEOUT_CYC(T), .TIMEOUT_DATA(TD), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .arst(arst),
        .m0_vld(m_vld[0][0]), .m0_we(m_we[0][0]), .m0_addr(m_addr[0][0]), .m0_wdat(m_wdat[0][0]),
        .m0_rdy(m_rdy[0][0]), .m0_rdat(m_rdat[0][0]),
        .m1_vld(m_vld[0][1]), .m1_we(m_we[0][1]), .m1_addr(m_addr[0][1]), .m1_wdat(m_wdat[0][1]),
        .m1_rdy(m_rdy[0][1]), .m1_rdat(m_rdat[0][1]),
        .s_vld(s_vld[0]), .s_we(s_we[0]), .s_addr(s_addr[0]), .s_wdat(s_wdat[0]),
        .s_rdy(s_rdy[0]), .s_rdat(s_rdat[0]),
        .gnt(gnt[0]), .tmo_pulse(tmo_pulse[0]), .tmo_cnt(tmo_cnt[0])
    );

    soc_bus_arb #(.TIMEOUT_CYC(T), .TIMEOUT_DATA(TD), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .arst(arst),
        .m0_vld(m_vld[1][0]), .m0_we(m_we[1][0]), .m0_addr(m_addr[1][0]), .m0_wdat(m_wdat[1][0]),
        .m0_rdy(m_rdy[1][0]), .m0_rdat(m_rdat[1][0]),
        .m1_vld(m_vld[1][1]), .m1_we(m_we[1][1]), .m1_addr(m_addr[1][1]), .m1_wdat(m_wdat[1][1]),
        .m1_rdy(m_rdy[1][1]), .m1_rdat(m_rdat[1][1]),
        .s_vld(s_vld[1]), .s_we(s_we[1]), .s_addr(s_addr[1]), .s_wdat(s_wdat[1]),
        .s_rdy(s_rdy[1]), .s_rdat(s_rdat[1]),
        .gnt(gnt[1]), .tmo_pulse(tmo_pulse[1]), .tmo_cnt(tmo_cnt[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_inst(input int i);
        md_cur[i]  = -1;
        md_age[i]  = 0;
        md_last[i] = 1;
        md_tmo[i]  = 0;
        exp_rdy_q[i][0] = 1'b0;
        exp_rdy_q[i][1] = 1'b0;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) begin
                m_vld[i][m] = 1'b0; m_we[i][m] = '0; m_addr[i][m] = '0; m_wdat[i][m] = '0;
            end
            s_rdy[i] = 1'b0; s_rdat[i] = '0;
        end
    endtask

    task automatic drive_m(input int m, input logic v, input logic [3:0] we,
                           input logic [29:0] a, input logic [31:0] d);
        for (int i = 0; i < 2; i++) begin
            m_vld[i][m] = v; m_we[i][m] = we; m_addr[i][m] = a; m_wdat[i][m] = d;
        end
    endtask

    task automatic drive_s(input logic r, input logic [31:0] d);
        for (int i = 0; i < 2; i++) begin
            s_rdy[i] = r; s_rdat[i] = d;
        end
    endtask

    task automatic release_done();
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < 2; m++)
                if (exp_rdy_q[i][m]) m_vld[i][m] = 1'b0;
    endtask

    // Check this cycle's outputs against the model, then advance the model over the edge.
    task automatic tick();
        logic        e_svld;
        logic [3:0]  e_swe;
        logic [29:0] e_saddr;
        logic [31:0] e_swdat;
        logic        e_rdy  [2];
        logic [31:0] e_rdat [2];
        logic [1:0]  e_gnt;
        int          g;
        bit          tmo;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (arst) reset_inst(i);
            g = md_cur[i];
            e_svld = 1'b0; e_swe = '0; e_saddr = '0; e_swdat = '0; e_gnt = '0; tmo = 1'b0;
            for (int m = 0; m < 2; m++) begin
                e_rdy[m] = 1'b0; e_rdat[m] = '0;
            end
            if (g >= 0) begin
                tmo       = (T != 0) && !s_rdy[i] && m_vld[i][g] && (md_age[i] == T - 1);
                e_svld    = m_vld[i][g] && !tmo;
                e_swe     = m_we[i][g];
                e_saddr   = m_addr[i][g];
                e_swdat   = m_wdat[i][g];
                e_rdy[g]  = s_rdy[i] || tmo;
                e_rdat[g] = tmo ? TD : s_rdat[i];
                e_gnt     = (g == 1) ? 2'b10 : 2'b01;
            end
            check($sformatf("i%0d s_vld", i), s_vld[i], e_svld);
            check($sformatf("i%0d s_we", i), s_we[i], e_swe);
            check($sformatf("i%0d s_addr", i), s_addr[i], e_saddr);
            check($sformatf("i%0d s_wdat", i), s_wdat[i], e_swdat);
            for (int m = 0; m < 2; m++) begin
                check($sformatf("i%0d m%0d_rdy", i, m), m_rdy[i][m], e_rdy[m]);
                check($sformatf("i%0d m%0d_rdat", i, m), m_rdat[i][m], e_rdat[m]);
                exp_rdy_q[i][m] = e_rdy[m];
            end
            check($sformatf("i%0d gnt", i), gnt[i], e_gnt);
            check($sformatf("i%0d tmo_pulse", i), tmo_pulse[i], tmo);
            check($sformatf("i%0d tmo_cnt", i), tmo_cnt[i], md_tmo[i]);

            if (arst) begin
                reset_inst(i);
            end else if (g < 0) begin
                if (m_vld[i][0] && m_vld[i][1]) begin
                    md_cur[i] = (i == 1) ? 0 : 1 - md_last[i];
                    md_age[i] = 0;
                end else if (m_vld[i][0] || m_vld[i][1]) begin
                    md_cur[i] = m_vld[i][1] ? 1 : 0;
                    md_age[i] = 0;
                end
            end else if (s_rdy[i]) begin
                md_last[i] = g;
                md_cur[i]  = -1;
            end else if (!m_vld[i][g]) begin
                md_cur[i] = -1;
            end else if (tmo) begin
                if (md_tmo[i] < 65535) md_tmo[i]++;
                md_last[i] = g;
                md_cur[i]  = -1;
            end else begin
                md_age[i]++;
            end
        end
        @(negedge clk);
    endtask

    function automatic int choose_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return r % 4;
        if (r == 6) return T - 1;
        return 40;
    endfunction

    task automatic run_auto(input int cycles, input int rate, input int fixed_lat,
                            input bit stray, input bit record);
        logic [1:0] prev_gnt [2];
        prev_gnt[0] = '0;
        prev_gnt[1] = '0;
        for (int c = 0; c < cycles; c++) begin
            if (record) begin
                if (gnt[0] != 2'b00 && prev_gnt[0] == 2'b00) gnt_log0.push_back(gnt[0]);
                if (gnt[1] == 2'b10 && prev_gnt[1] == 2'b00 && m_vld[1][0]) fp_viol++;
            end
            prev_gnt[0] = gnt[0];
            prev_gnt[1] = gnt[1];
            for (int i = 0; i < 2; i++) begin
                for (int m = 0; m < 2; m++) begin
                    if (exp_rdy_q[i][m]) begin
                        m_vld[i][m] = 1'b0;
                    end else if (!m_vld[i][m] && $urandom_range(1, 100) <= rate) begin
                        m_vld[i][m]  = 1'b1;
                        m_we[i][m]   = 4'($urandom);
                        m_addr[i][m] = 30'($urandom);
                        m_wdat[i][m] = $urandom;
                    end
                end
                s_rdat[i] = $urandom;
                if (md_cur[i] >= 0) begin
                    if (md_age[i] == 0) slave_lat[i] = (fixed_lat >= 0) ? fixed_lat : choose_lat();
                    s_rdy[i] = (md_age[i] == slave_lat[i]);
                end else begin
                    s_rdy[i] = stray && ($urandom_range(0, 7) == 0);
                end
            end
            tick();
        end
    endtask

    initial begin
        int pulses;
        arst = 1'b1;
        idle_all();
        reset_inst(0);
        reset_inst(1);
        #1;
        check("reset s_vld", s_vld[0], 1'b0);
        check("reset gnt", gnt[0], 2'b00);
        check("reset tmo_cnt", tmo_cnt[0], 16'd0);
        check("reset m0_rdat", m_rdat[0][0], 32'd0);
        repeat (2) tick();
        arst = 1'b0;

        // Single m0 read, slave answers on the third bus cycle.
        drive_m(0, 1'b1, 4'h0, 30'h0400_0000, 32'h0);
        #1 check("rd idle s_vld", s_vld[0], 1'b0);
        tick();
        #1 check("rd s_vld", s_vld[0], 1'b1);
        check("rd gnt", gnt[0], 2'b01);
        check("rd s_addr", s_addr[0], 30'h0400_0000);
        tick();
        tick();
        drive_s(1'b1, 32'h1234_5678);
        #1 check("rd m0_rdy", m_rdy[0][0], 1'b1);
        check("rd m0_rdat", m_rdat[0][0], 32'h1234_5678);
        check("rd m1_rdy", m_rdy[0][1], 1'b0);
        tick();
        drive_m(0, 1'b0, 4'h0, 30'h0, 32'h0);
        drive_s(1'b0, 32'h0);
        #1 check("rd gnt after", gnt[0], 2'b00);
        tick();

        // Simultaneous requests after an m0 completion: policies diverge.
        drive_m(0, 1'b1, 4'hF, 30'h11, 32'hA0);
        drive_m(1, 1'b1, 4'h3, 30'h22, 32'hB1);
        tick();
        #1 check("rr pick", gnt[0], 2'b10);
        check("fp pick", gnt[1], 2'b01);
        check("rr fwd addr", s_addr[0], 30'h22);
        check("fp fwd addr", s_addr[1], 30'h11);
        drive_s(1'b1, 32'h5555);
        tick();
        release_done();
        drive_s(1'b0, 32'h0);
        tick();
        #1 check("rr second", gnt[0], 2'b01);
        check("fp second", gnt[1], 2'b10);
        drive_s(1'b1, 32'h6666);
        tick();
        release_done();
        drive_s(1'b0, 32'h0);
        tick();

        // Hung slave on an m1 write: watchdog completes on the 16th bus cycle.
        drive_m(1, 1'b1, 4'hF, 30'h0ABC, 32'hCAFE_F00D);
        tick();
        pulses = 0;
        for (int k = 0; k < T; k++) begin
            #1;
            if (k == 0) check("tmo s_wdat", s_wdat[0], 32'hCAFE_F00D);
            if (k == T - 1) begin
                check("tmo m1_rdy", m_rdy[0][1], 1'b1);
                check("tmo m1_rdat", m_rdat[0][1], 32'hDEAD_BEEF);
                check("tmo s_vld", s_vld[0], 1'b0);
            end
            pulses += int'(tmo_pulse[0]);
            tick();
        end
        release_done();
        #1 check("tmo pulses", pulses, 1);
        check("tmo_cnt", tmo_cnt[0], 16'd1);
        check("tmo gnt", gnt[0], 2'b00);
        tick();
        tick();
        drive_s(1'b1, 32'h7777_0000);
        #1 check("late m0_rdy", m_rdy[0][0], 1'b0);
        check("late m1_rdy", m_rdy[0][1], 1'b0);
        tick();
        drive_s(1'b0, 32'h0);

        // Slave answers in the very cycle the watchdog would expire.
        drive_m(0, 1'b1, 4'h0, 30'h3, 32'h0);
        tick();
        for (int k = 0; k < T; k++) begin
            if (k == T - 1) drive_s(1'b1, 32'hA5A5_0001);
            #1;
            if (k == T - 1) begin
                check("coin m0_rdy", m_rdy[0][0], 1'b1);
                check("coin m0_rdat", m_rdat[0][0], 32'hA5A5_0001);
                check("coin tmo_pulse", tmo_pulse[0], 1'b0);
            end
            tick();
        end
        drive_s(1'b0, 32'h0);
        release_done();
        #1 check("coin tmo_cnt", tmo_cnt[0], 16'd1);
        tick();

        // Reset while a slave completion is pending.
        drive_m(0, 1'b1, 4'h0, 30'h44, 32'h0);
        tick();
        drive_s(1'b1, 32'h9999);
        #2 arst = 1'b1;
        #1 check("arst s_vld", s_vld[0], 1'b0);
        check("arst m0_rdy", m_rdy[0][0], 1'b0);
        check("arst gnt", gnt[0], 2'b00);
        check("arst tmo_cnt", tmo_cnt[0], 16'd0);
        tick();
        arst = 1'b0;
        drive_s(1'b0, 32'h0);
        drive_m(0, 1'b1, 4'h1, 30'h55, 32'h1);
        drive_m(1, 1'b1, 4'h2, 30'h66, 32'h2);
        tick();
        #1 check("post-rst rr", gnt[0], 2'b01);
        check("post-rst fp", gnt[1], 2'b01);

        // Continuous requests from both masters with a single-cycle slave.
        run_auto(30, 100, 0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++)
            check($sformatf("rr seq %0d", k), (k < gnt_log0.size()) ? gnt_log0[k] : 2'b00,
                  (k % 2 == 0) ? 2'b01 : 2'b10);
        check("fp m1 while m0 vld", fp_viol, 0);

        // Random traffic, latencies, stray slave pulses and timeouts.
        for (int b = 0; b < 8; b++)
            run_auto(500, $urandom_range(10, 100), -1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
